seven_seg_scan: RTL
===================

# seven_seg_scan

Multiplexed six-digit seven-segment display driver that consumes the 24-bit packed BCD value produced by the binary-to-BCD converter. It captures a new value on the converter's one-cycle `done` pulse, holds it in a shadow register, and time-multiplexes the six digits onto shared active-low segment lines. Each digit slot ends with an anti-ghosting guard interval. Optional leading-zero blanking and per-digit decimal points are supported.

## Interface
- SCAN_DIV, 50000: clk cycles per digit slot; legal range ≥ 2.
- GUARD, 500: all-off cycles at the start of each slot; legal range 0 ≤ GUARD < SCAN_DIV.
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous, active-low.
- bcd_in  input  24  packed BCD; digit k = bcd_in[4k+3:4k]; digit 0 is the rightmost.
- load  input  1  one-cycle capture strobe, driven by converter `done`.
- blank_lz  input  1  1 = blank leading zeros.
- dp_mask  input  6  bit k = 1 lights the decimal point of digit k; sampled live, not shadowed.
- seg_n  output  8  {dp,g,f,e,d,c,b,a}, active low, registered.
- dig_n  output  6  digit enables, bit k drives digit k, active low, registered, at most one bit low.

## Operation
- Shadow register `shd[23:0]`:
  - On a clk edge with load=1, shd ← bcd_in.
  - Otherwise shd holds.
  - A load pulse longer than one cycle is legal; the last sampled value wins.
- Scan counter `cnt`: counts 0..SCAN_DIV-1 and wraps to 0.
- Digit index `idx`: 0..5; advances on the cnt wrap, 5→0.
- Slot phases (from cnt):
  - GUARD phase, cnt < GUARD: next outputs are dig_n=6'h3F, seg_n=8'hFF.
  - ON phase, cnt ≥ GUARD: next dig_n has bit idx low; next seg_n = decode(shd nibble idx) with dp = ~dp_mask[idx].
- Decode, segments a..g active low:
  - 0–9: standard glyphs (1 = b,c; 7 = a,b,c).
  - Nibble 10–15 is not valid BCD and displays a dash (g only).
- Leading-zero blanking, when blank_lz=1:
  - Digit k (k = 1..5) is blanked when every nibble k..5 of shd is 0.
  - Digit 0 is never blanked.
  - A blanked digit keeps its enable active, drives segments a–g off, and still honours dp_mask.
- load, blank_lz and dp_mask are independent of the scan. A load mid-slot changes the displayed glyph within that slot; no frame synchronisation is applied.

## Timing
- Reset values (asynchronous): seg_n=8'hFF, dig_n=6'h3F, cnt=0, idx=0, shd=24'h0.
- Output register: outputs at edge n reflect cnt, idx and shd from before edge n, i.e. one cycle of latency.
- First digit after reset release: dig_n[0] first goes low on the (GUARD+1)th rising edge.
- Slot timing: each digit is enabled for exactly SCAN_DIV-GUARD consecutive cycles, followed by GUARD all-off cycles.
- Frame period: 6·SCAN_DIV cycles; digit order 0,1,2,3,4,5,0,…
- Load latency: a load on edge n makes the new value visible on seg_n from edge n+1, if that digit is in its ON phase.
- GUARD=0: no off cycles; dig_n switches directly from one digit to the next on the same edge as seg_n.
- Load coinciding with a cnt wrap: the new digit is shown with the new shd value.
- Reset asserted mid-frame: outputs go to their reset values immediately. After release, scanning restarts at digit 0 with shd=0; the previously displayed value is lost.

## Test plan
All scenarios use SCAN_DIV=8 and GUARD=2 unless stated.
- Reset, no load → shd=0; digit 0 shows "0" (seg_n=8'hC0) for 6 cycles starting at the 3rd edge after reset release. Digits 1–5 also show "0" when blank_lz=0, and show segments off (seg_n=8'hFF) with enable low when blank_lz=1.
- load pulse with bcd_in=24'h123456, blank_lz=0 → across one 48-cycle frame, digits 0..5 show 6,5,4,3,2,1 (seg_n 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9). Each digit is enabled for 6 cycles, with exactly 2 all-off cycles between digits.
- Leading-zero blanking: bcd_in=24'h000705, blank_lz=1 → digits 3–5 blanked; digit 2 shows "7" (8'hF8); digit 1 shows "0" (8'hC0), an embedded zero that is not blanked.
- Decimal point: dp_mask=6'b000100 with value 24'h000705 → digit 2 seg_n=8'h78; all other digits have seg_n[7]=1.
- Invalid BCD: bcd_in=24'h00000A → digit 0 shows a dash (seg_n=8'hBF).
- Load mid-slot, then reset: a load of 24'h000009 during digit 0's ON phase (prior value 0) changes seg_n from 8'hC0 to 8'h90 one cycle later. rst_n asserted during digit 3 → seg_n=8'hFF and dig_n=6'h3F immediately; after release, digit 0 is the first digit enabled and shows "0".

Source files
------------

// File: rtl/seven_seg_scan.sv
// Six-digit multiplexed seven-segment driver.
// Captures packed BCD on a load strobe into a shadow register. Scans one digit
// per SCAN_DIV cycles, and blanks all outputs for the first GUARD cycles of each
// slot so that a digit does not ghost onto its neighbour.
// Outputs are active low and registered, so they lag the scan state by one cycle.
module seven_seg_scan #(
    parameter int unsigned SCAN_DIV = 50000,
    parameter int unsigned GUARD    = 500
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [23:0] bcd_in,
    input  logic        load,
    input  logic        blank_lz,
    input  logic [5:0]  dp_mask,
    output logic [7:0]  seg_n,
    output logic [5:0]  dig_n
);

    localparam int unsigned   CW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);

    logic [23:0]   shd;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic          in_guard;
    logic [5:0]    blank;
    logic [3:0]    nib;
    logic          dp_on;
    logic          blk;
    logic [6:0]    glyph;
    logic [5:0]    dig_on;
    logic [7:0]    seg_next;
    logic [5:0]    dig_next;

    // Shadow register: the last value presented with load high is kept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shd <= '0;
        end else if (load) begin
            shd <= bcd_in;
        end
    end

    // Slot counter and digit index. The index steps 0..5 on each slot wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // A GUARD of zero has no off phase. Handling it separately avoids a
    // comparison against zero that would always be false.
    generate
        if (GUARD == 0) begin : g_no_guard
            assign in_guard = 1'b0;
        end else begin : g_guard
            assign in_guard = (cnt < CW'(GUARD));
        end
    endgenerate

    // Leading-zero mask. Digit k is blank when nibbles k..5 are all zero.
    // Digit 0 is never blank.
    always_comb begin
        logic run;
        run   = 1'b1;
        blank = '0;
        for (int unsigned i = 0; i < 6; i++) begin
            run = run & (shd[4*(5-i) +: 4] == 4'h0);
            blank[5-i] = blank_lz & run & ((5 - i) != 0);
        end
    end

    // Select the nibble, decimal point, blanking flag and enable for the current digit
    always_comb begin
        nib    = '0;
        dp_on  = 1'b0;
        blk    = 1'b0;
        dig_on = '1;
        case (idx)
            3'd0: begin nib = shd[3:0];   dp_on = dp_mask[0]; blk = blank[0]; dig_on = 6'b111110; end
            3'd1: begin nib = shd[7:4];   dp_on = dp_mask[1]; blk = blank[1]; dig_on = 6'b111101; end
            3'd2: begin nib = shd[11:8];  dp_on = dp_mask[2]; blk = blank[2]; dig_on = 6'b111011; end
            3'd3: begin nib = shd[15:12]; dp_on = dp_mask[3]; blk = blank[3]; dig_on = 6'b110111; end
            3'd4: begin nib = shd[19:16]; dp_on = dp_mask[4]; blk = blank[4]; dig_on = 6'b101111; end
            3'd5: begin nib = shd[23:20]; dp_on = dp_mask[5]; blk = blank[5]; dig_on = 6'b011111; end
            default: begin end
        endcase
    end

    // Glyph decode, {g,f,e,d,c,b,a} active low. Non-BCD nibbles show a dash
    always_comb begin
        glyph = 7'h3F;
        case (nib)
            4'd0: glyph = 7'h40;
            4'd1: glyph = 7'h79;
            4'd2: glyph = 7'h24;
            4'd3: glyph = 7'h30;
            4'd4: glyph = 7'h19;
            4'd5: glyph = 7'h12;
            4'd6: glyph = 7'h02;
            4'd7: glyph = 7'h78;
            4'd8: glyph = 7'h00;
            4'd9: glyph = 7'h10;
            default: glyph = 7'h3F;
        endcase
    end

    // Next output value: all off during guard. Otherwise the digit glyph, which
    // may be blank, with its decimal point.
    always_comb begin
        seg_next = 8'hFF;
        dig_next = 6'h3F;
        if (!in_guard) begin
            seg_next = {~dp_on, (blk ? 7'h7F : glyph)};
            dig_next = dig_on;
        end
    end

    // Registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_n <= 8'hFF;
            dig_n <= 6'h3F;
        end else begin
            seg_n <= seg_next;
            dig_n <= dig_next;
        end
    end

endmodule
